// File: rtl/cpu_bus_target_if.sv
// CPU-side address/data/RW bus shared by the core and its memory responder.
// Latency: wires only; read data is returned by the target one cycle after the address.
// Backpressure: none, because the core presents a new bus cycle every clock.
interface cpu_bus_target_if;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (output addr, output rw, output wdata, input rdata);
    modport slave  (input addr, input rw, input wdata, output rdata);
endinterface

// File: rtl/cpu_bus_target.sv
// Memory-side responder for the core bus: on-chip RAM, vector window, 8-register timer/GPIO block.
// Latency: read data is registered, so it appears one cycle after its address. Writes commit at the end of their cycle.
// Backpressure: none. Every bus cycle is accepted, and unmapped writes are silently dropped.
module cpu_bus_target #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] IO_BASE   = 16'hD000,
    parameter logic [15:0] RESET_VEC = 16'hF000,
    parameter int          PRESCALE  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    cpu_bus_target_if.slave     bus,
    output logic [7:0]          gpio_out,
    output logic                irq
);

    localparam int RAM_SIZE = 1 << RAM_AW;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    // I/O register offsets inside the 8-byte block
    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_STATUS    = 3'd1;
    localparam logic [2:0] OFF_RELOAD_LO = 3'd2;
    localparam logic [2:0] OFF_RELOAD_HI = 3'd3;
    localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
    localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
    localparam logic [2:0] OFF_GPIO      = 3'd6;
    localparam logic [2:0] OFF_SCRATCH   = 3'd7;

    // Storage
    logic [7:0]    mem [RAM_SIZE];
    logic [7:0]    rdata_q;
    logic [2:0]    ctrl_q;        // b0 timer_en, b1 irq_en, b2 autoreload
    logic          flag_q;
    logic [15:0]   reload_q;
    logic [15:0]   count_q;
    logic [7:0]    shadow_q;
    logic [7:0]    gpio_q;
    logic [7:0]    scratch_q;
    logic [PW-1:0] presc_q;
    logic          irq_q;

    // Decode
    logic              sel_vec;
    logic              sel_io;
    logic              sel_ram;
    logic [2:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_rd;
    logic              io_wr;
    logic              ram_wr;
    logic              rd_count_lo;
    logic [7:0]        rd_mux;

    // Timer events
    logic tick;
    logic flag_set;

    // The vector window sits at the very top of the map and overrides anything
    // else that might be placed there. The I/O block comes next, then RAM.
    assign sel_vec = (bus.addr >= 16'hFFFA);
    assign sel_io  = !sel_vec && (bus.addr[15:3] == IO_BASE[15:3]);
    assign sel_ram = !sel_vec && !sel_io && ((bus.addr >> RAM_AW) == 16'd0);
    assign io_off  = bus.addr[2:0];
    assign ram_idx = bus.addr[RAM_AW-1:0];

    assign is_rd       = bus.rw;
    assign io_wr       = !bus.rw && sel_io;
    assign ram_wr      = !bus.rw && sel_ram;
    assign rd_count_lo = is_rd && sel_io && (io_off == OFF_COUNT_LO);

    // One tick per prescaler wrap while the timer runs. An expiring tick
    // (count already at zero) is what raises the flag.
    assign tick     = ctrl_q[0] && (presc_q == PRESC_MAX);
    assign flag_set = tick && (count_q == 16'd0);

    // Read data selection for the current address. Unmapped reads float high.
    always_comb begin
        rd_mux = 8'hFF;
        if (sel_vec) begin
            rd_mux = bus.addr[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];
        end else if (sel_io) begin
            case (io_off)
                OFF_CTRL:      rd_mux = {5'b0, ctrl_q};
                OFF_STATUS:    rd_mux = {7'b0, flag_q};
                OFF_RELOAD_LO: rd_mux = reload_q[7:0];
                OFF_RELOAD_HI: rd_mux = reload_q[15:8];
                OFF_COUNT_LO:  rd_mux = count_q[7:0];
                OFF_COUNT_HI:  rd_mux = shadow_q;
                OFF_GPIO:      rd_mux = gpio_q;
                OFF_SCRATCH:   rd_mux = scratch_q;
                default:       rd_mux = 8'hFF;
            endcase
        end else if (sel_ram) begin
            rd_mux = mem[ram_idx];
        end
    end

    // RAM array. It has no reset, so its contents survive reset_n.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_idx] <= bus.wdata;
        end
    end

    // Registered read data. It holds its value through write cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 8'h00;
        end else if (is_rd) begin
            rdata_q <= rd_mux;
        end
    end

    // A COUNT_LO read captures the high byte so that the HI read that follows
    // sees the same 16-bit snapshot, even if the counter has moved on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= 8'h00;
        end else if (rd_count_lo) begin
            shadow_q <= count_q[15:8];
        end
    end

    // Prescaler runs only while the timer is enabled and restarts on each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (!ctrl_q[0] || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Timer and control state. Timer effects are assigned first, so a CPU write
    // in the same cycle takes precedence (for example, a CTRL write wins over the
    // one-shot auto-disable). The only exception is the W1C clear, which is
    // explicitly blocked when the flag is being set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= 3'b000;
            flag_q    <= 1'b0;
            reload_q  <= 16'h0000;
            count_q   <= 16'h0000;
            gpio_q    <= 8'h00;
            scratch_q <= 8'h00;
        end else begin
            if (tick) begin
                if (count_q != 16'd0) begin
                    count_q <= count_q - 16'd1;
                end else begin
                    flag_q <= 1'b1;
                    if (ctrl_q[2]) begin
                        count_q <= reload_q;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                    end
                end
            end

            if (io_wr) begin
                case (io_off)
                    OFF_CTRL: begin
                        ctrl_q <= bus.wdata[2:0];
                    end
                    OFF_STATUS: begin
                        if (bus.wdata[0] && !flag_set) begin
                            flag_q <= 1'b0;
                        end
                    end
                    OFF_RELOAD_LO: begin
                        reload_q[7:0] <= bus.wdata;
                    end
                    OFF_RELOAD_HI: begin
                        reload_q[15:8] <= bus.wdata;
                        // A stopped timer is preloaded, so that enabling it starts from RELOAD.
                        if (!ctrl_q[0]) begin
                            count_q <= {bus.wdata, reload_q[7:0]};
                        end
                    end
                    OFF_GPIO: begin
                        gpio_q <= bus.wdata;
                    end
                    OFF_SCRATCH: begin
                        scratch_q <= bus.wdata;
                    end
                    default: begin
                        // COUNT_LO/COUNT_HI are read-only
                    end
                endcase
            end
        end
    end

    // Interrupt line is registered, so it follows flag/irq_en by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= flag_q & ctrl_q[1];
        end
    end

    assign bus.rdata = rdata_q;
    assign gpio_out  = gpio_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_cpu_bus_target.sv
// Self-checking bench for cpu_bus_target, using directed scenarios plus a randomized mix.
// Latency: inputs are driven on the falling edge and outputs are sampled 1 time unit after the rising edge.
// Backpressure: not applicable, since the bus accepts one cycle per clock.
module tb_cpu_bus_target;

    localparam int          P   = 8;
    localparam logic [15:0] IOB = 16'hD000;
    localparam logic [15:0] RV  = 16'hF000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] gpio_out;
    logic       irq;

    cpu_bus_target_if bus();

    cpu_bus_target #(
        .RAM_AW   (10),
        .IO_BASE  (IOB),
        .RESET_VEC(RV),
        .PRESCALE (P)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .gpio_out(gpio_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: plain integers that track the register map, the timer and the RAM.
    int m_mem [1024];
    int m_ctrl, m_flag, m_reload, m_count, m_shadow, m_gpio, m_scratch, m_presc, m_irq, m_rdata;

    task automatic model_reset();
        m_ctrl = 0; m_flag = 0; m_reload = 0; m_count = 0; m_shadow = 0;
        m_gpio = 0; m_scratch = 0; m_presc = 0; m_irq = 0; m_rdata = 0;
    endtask

    function automatic int model_read(input int a);
        if (a >= 'hFFFA) return (a % 2 == 0) ? int'(RV) % 256 : int'(RV) / 256;
        if (a / 8 == int'(IOB) / 8) begin
            case (a % 8)
                0: return m_ctrl;
                1: return m_flag;
                2: return m_reload % 256;
                3: return m_reload / 256;
                4: return m_count % 256;
                5: return m_shadow;
                6: return m_gpio;
                default: return m_scratch;
            endcase
        end
        if (a < 1024) return m_mem[a];
        return 255;
    endfunction

    // Applies one clock edge of bus activity to the model, with every rule evaluated on pre-edge values.
    task automatic model_edge(input int a, input bit r, input int d);
        int  o_ctrl;
        int  o_count;
        bit  tick;
        bit  set_now;
        bit  io;
        o_ctrl  = m_ctrl;
        o_count = m_count;
        tick    = (o_ctrl % 2 == 1) && (m_presc == P - 1);
        set_now = tick && (o_count == 0);
        io      = (a < 'hFFFA) && (a / 8 == int'(IOB) / 8);
        m_irq   = (m_flag == 1 && (o_ctrl / 2) % 2 == 1) ? 1 : 0;
        if (r) begin
            m_rdata = model_read(a);
            if (io && a % 8 == 4) m_shadow = o_count / 256;
        end
        m_presc = (tick || o_ctrl % 2 == 0) ? 0 : m_presc + 1;
        if (tick && o_count != 0) m_count = o_count - 1;
        if (set_now) begin
            m_flag = 1;
            if ((o_ctrl / 4) % 2 == 1) m_count = m_reload;
            else m_ctrl = o_ctrl - 1;
        end
        if (!r) begin
            if (io) begin
                case (a % 8)
                    0: m_ctrl = d % 8;
                    1: if (d % 2 == 1 && !set_now) m_flag = 0;
                    2: m_reload = (m_reload / 256) * 256 + d;
                    3: begin
                        if (o_ctrl % 2 == 0) m_count = d * 256 + m_reload % 256;
                        m_reload = d * 256 + m_reload % 256;
                    end
                    6: m_gpio = d;
                    7: m_scratch = d;
                    default: ;
                endcase
            end else if (a < 'hFFFA && a < 1024) begin
                m_mem[a] = d;
            end
        end
    endtask

    // One bus cycle: drive on the falling edge, advance the model at the rising edge, then settle.
    task automatic cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.rw = r; bus.wdata = d;
        @(posedge clk);
        if (reset_n) model_edge(int'(a), r, int'(d));
        cyc++;
        #1;
    endtask

    task automatic rd(input logic [15:0] a);
        cycle(a, 1'b1, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cycle(a, 1'b0, d);
    endtask

    // Releases reset with a read of 0xFFFC already on the bus, so the first edge is a normal read.
    task automatic release_reset();
        @(negedge clk);
        bus.addr = 16'hFFFC; bus.rw = 1'b1; bus.wdata = 8'h00;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        model_edge('hFFFC, 1'b1, 0);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.addr = 16'($urandom); bus.rw = 1'($urandom); bus.wdata = 8'($urandom);
            if (i == 2) begin bus.addr = IOB + 16'd6; bus.rw = 1'b0; end
            @(posedge clk); #1;
        end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", bus.rdata); end
        tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL reset_gpio got %h want 00", gpio_out); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
        release_reset();
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL vec_fffc got %h want 00", bus.rdata); end
        rd(16'hFFFD);
        tests++; if (bus.rdata !== 8'hF0) begin fails++; $display("FAIL vec_fffd got %h want f0", bus.rdata); end
    endtask

    task automatic test_ram();
        int a;
        wr(16'h0123, 8'h5A);
        rd(16'h0123);
        tests++; if (bus.rdata !== 8'h5A) begin fails++; $display("FAIL ram_raw got %h want 5a", bus.rdata); end
        wr(16'h0124, 8'h11);
        tests++; if (bus.rdata !== 8'h5A) begin fails++; $display("FAIL rdata_hold_on_write got %h want 5a", bus.rdata); end
        rd(16'h8000);
        tests++; if (bus.rdata !== 8'hFF) begin fails++; $display("FAIL unmapped_8000 got %h want ff", bus.rdata); end
        wr(16'h0400, 8'h77);
        rd(16'h0400);
        tests++; if (bus.rdata !== 8'hFF) begin fails++; $display("FAIL unmapped_0400 got %h want ff", bus.rdata); end
        wr(16'hFFFE, 8'h12);
        rd(16'hFFFE);
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL vec_write_ignored got %h want 00", bus.rdata); end
        rd(16'hFFF9);
        tests++; if (bus.rdata !== 8'hFF) begin fails++; $display("FAIL below_vec got %h want ff", bus.rdata); end
        wr(16'h03FF, 8'hC3);
        rd(16'h03FF);
        tests++; if (bus.rdata !== 8'hC3) begin fails++; $display("FAIL ram_top got %h want c3", bus.rdata); end
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 1023);
            wr(16'(a), 8'($urandom));
            rd(16'(a));
            tests++;
            if (bus.rdata !== 8'(m_mem[a])) begin
                fails++; $display("FAIL ram_rand addr %h got %h want %h", a, bus.rdata, 8'(m_mem[a]));
            end
        end
    endtask

    task automatic test_timer_oneshot();
        int first;
        wr(IOB + 16'd2, 8'h02);
        wr(IOB + 16'd3, 8'h00);
        wr(IOB + 16'd0, 8'h03);
        first = 0;
        for (int k = 1; k <= 4 * P + 4; k++) begin
            rd(IOB + 16'd1);
            if (irq === 1'b1 && first == 0) first = k;
        end
        tests++; if (first != 3 * P + 1) begin fails++; $display("FAIL oneshot_irq_delay got %0d want %0d", first, 3 * P + 1); end
        rd(IOB + 16'd0);
        tests++; if (bus.rdata !== 8'h02) begin fails++; $display("FAIL oneshot_ctrl got %h want 02", bus.rdata); end
        rd(IOB + 16'd4);
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL oneshot_count got %h want 00", bus.rdata); end
        wr(IOB + 16'd1, 8'h01);
        rd(IOB + 16'd1);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq got %b want 0", irq); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL w1c_flag got %h want 00", bus.rdata); end
    endtask

    task automatic test_autoreload();
        int  rise [3];
        bit  ok;
        wr(IOB + 16'd0, 8'h00);
        wr(IOB + 16'd2, 8'h01);
        wr(IOB + 16'd3, 8'h00);
        wr(IOB + 16'd1, 8'h01);
        wr(IOB + 16'd0, 8'h07);
        for (int n = 0; n < 3; n++) begin
            ok = 0;
            for (int k = 0; k < 4 * P && !ok; k++) begin
                rd(IOB + 16'd1);
                tests++; if (irq !== 1'(m_irq)) begin fails++; $display("FAIL auto_irq_trace got %b want %0d", irq, m_irq); end
                if (irq === 1'b1) begin ok = 1; rise[n] = cyc; end
            end
            tests++; if (!ok) begin fails++; $display("FAIL auto_irq_timeout got 0 want 1"); end
            wr(IOB + 16'd1, 8'h01);
            for (int k = 0; k < 4 && irq === 1'b1; k++) rd(IOB + 16'd1);
        end
        tests++; if (rise[1] - rise[0] != 2 * P) begin fails++; $display("FAIL auto_period1 got %0d want %0d", rise[1] - rise[0], 2 * P); end
        tests++; if (rise[2] - rise[1] != 2 * P) begin fails++; $display("FAIL auto_period2 got %0d want %0d", rise[2] - rise[1], 2 * P); end
        // Issue the W1C exactly in the cycle whose closing edge sets the flag.
        ok = 0;
        for (int k = 0; k < 4 * P && !ok; k++) begin
            if (m_ctrl % 2 == 1 && m_presc == P - 1 && m_count == 0) ok = 1;
            else rd(IOB + 16'd7);
        end
        tests++; if (!ok) begin fails++; $display("FAIL auto_find_tick got 0 want 1"); end
        wr(IOB + 16'd1, 8'h01);
        rd(IOB + 16'd1);
        tests++; if (bus.rdata !== 8'h01) begin fails++; $display("FAIL w1c_vs_set got %h want 01", bus.rdata); end
    endtask

    task automatic test_coherent_count();
        bit ok;
        logic [7:0] lo;
        wr(IOB + 16'd0, 8'h00);
        wr(IOB + 16'd2, 8'h00);
        wr(IOB + 16'd3, 8'h01);
        wr(IOB + 16'd1, 8'h01);
        wr(IOB + 16'd0, 8'h01);
        ok = 0;
        for (int k = 0; k < 2 * P && !ok; k++) begin
            if (m_presc == P - 1) ok = 1;
            else rd(IOB + 16'd7);
        end
        tests++; if (!ok) begin fails++; $display("FAIL coh_find_tick got 0 want 1"); end
        rd(IOB + 16'd4);
        lo = bus.rdata;
        rd(IOB + 16'd5);
        tests++; if ({bus.rdata, lo} !== 16'h0100) begin fails++; $display("FAIL coh_pair got %h want 0100", {bus.rdata, lo}); end
        rd(IOB + 16'd4);
        tests++; if (bus.rdata !== 8'hFF) begin fails++; $display("FAIL coh_after_lo got %h want ff", bus.rdata); end
        rd(IOB + 16'd5);
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL coh_after_hi got %h want 00", bus.rdata); end
        wr(IOB + 16'd0, 8'h00);
    endtask

    task automatic test_gpio_scratch();
        wr(IOB + 16'd6, 8'hA5);
        tests++; if (gpio_out !== 8'hA5) begin fails++; $display("FAIL gpio_out got %h want a5", gpio_out); end
        wr(IOB + 16'd7, 8'h3C);
        rd(IOB + 16'd7);
        tests++; if (bus.rdata !== 8'h3C) begin fails++; $display("FAIL scratch got %h want 3c", bus.rdata); end
        rd(IOB + 16'd6);
        tests++; if (bus.rdata !== 8'hA5) begin fails++; $display("FAIL gpio_read got %h want a5", bus.rdata); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL async_reset_gpio got %h want 00", gpio_out); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL async_reset_rdata got %h want 00", bus.rdata); end
        release_reset();
        rd(IOB + 16'd6);
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL gpio_after_reset got %h want 00", bus.rdata); end
    endtask

    task automatic test_random();
        int pool [8];
        int sel;
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, 1023);
            wr(16'(pool[i]), 8'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = IOB + 16'($urandom_range(0, 7));
                4:          a = IOB + 16'd4 + 16'($urandom_range(0, 1));
                5, 6:       a = 16'(pool[$urandom_range(0, 7)]);
                7:          a = 16'hFFFA + 16'($urandom_range(0, 5));
                default:    a = 16'($urandom_range('h0400, 'hCFFF));
            endcase
            cycle(a, 1'($urandom_range(0, 2) != 0), 8'($urandom));
            tests++;
            if ({bus.rdata, gpio_out, irq} !== {8'(m_rdata), 8'(m_gpio), 1'(m_irq)}) begin
                fails++;
                $display("FAIL random cyc %0d addr %h got rd=%h gpio=%h irq=%b want rd=%h gpio=%h irq=%0d",
                         n, a, bus.rdata, gpio_out, irq, 8'(m_rdata), 8'(m_gpio), m_irq);
            end
        end
    endtask

    initial begin
        bus.addr = 16'h0000; bus.rw = 1'b1; bus.wdata = 8'h00;
        model_reset();
        test_reset();
        test_ram();
        test_timer_oneshot();
        test_autoreload();
        test_coherent_count();
        test_gpio_scratch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
